// File: rtl/lock_btn_conditioner.sv
// Button front-end for the digital lock: synchronizes and debounces five raw
// buttons and issues at most one registered press pulse per clock, by priority.
module lock_btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic enable,
  input  logic rst_btn,
  input  logic raw_mod3,
  input  logic raw_mod10,
  input  logic raw_confirm,
  input  logic raw_enter,
  input  logic raw_mode,
  output logic mod3_btn,
  output logic mod10_btn,
  output logic confirm,
  output logic enter,
  output logic mode,
  output logic busy
);

  localparam int NCH = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NCH-1:0] raw;
  logic [NCH-1:0] press;
  logic [NCH-1:0] grant;
  logic [NCH-1:0] pend_reg;
  logic [NCH-1:0] pend_next;
  logic [NCH-1:0] pulse_reg;
  logic           busy_reg;

  // Index 0 is the highest-priority channel.
  assign raw = {raw_mode, raw_enter, raw_confirm, raw_mod10, raw_mod3};

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic             s1_reg;
      logic             s2_reg;
      logic             db_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge enable) begin
        if (rst_btn) begin
          s1_reg  <= 1'b0;
          s2_reg  <= 1'b0;
          db_reg  <= 1'b0;
          cnt_reg <= '0;
        end else begin
          s1_reg <= raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == db_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == CNT_LAST) begin
            db_reg  <= s2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      // High on exactly the clock where the stable level is about to go 0->1.
      assign press[gi] = s2_reg & ~db_reg & (cnt_reg == CNT_LAST);
    end
  endgenerate

  // Isolate the lowest set pending bit; a fresh press re-arms a bit being granted.
  assign grant     = pend_reg & (-pend_reg);
  assign pend_next = (pend_reg & ~grant) | press;

  always_ff @(posedge enable) begin
    if (rst_btn) begin
      pend_reg  <= '0;
      pulse_reg <= '0;
      busy_reg  <= 1'b0;
    end else begin
      pend_reg  <= pend_next;
      pulse_reg <= grant;
      busy_reg  <= |pend_next;
    end
  end

  assign mod3_btn  = pulse_reg[0];
  assign mod10_btn = pulse_reg[1];
  assign confirm   = pulse_reg[2];
  assign enter     = pulse_reg[3];
  assign mode      = pulse_reg[4];
  assign busy      = busy_reg;

endmodule

// File: tb/tb_lock_btn_conditioner.sv
// Bench for lock_btn_conditioner: three instances (debounce 4, 2, 1) checked
// every clock against a reference model, plus table and hand-written sequences.
module tb_lock_btn_conditioner;

  localparam int NI = 3;

  typedef struct {
    logic [4:0] raw;
    logic       rst;
    logic [5:0] exp;  // {busy, mode, enter, confirm, mod10, mod3}
  } vec_t;

  logic       enable = 1'b0;
  logic       rst_btn;
  logic [4:0] raw;
  logic [4:0] pulse [NI];
  logic       busy [NI];

  always #5 enable = ~enable;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    lock_btn_conditioner #(
      .DEBOUNCE_CYCLES(gi == 0 ? 4 : (gi == 1 ? 2 : 1)),
      .CNT_W(8)
    ) u_dut (
      .enable     (enable),
      .rst_btn    (rst_btn),
      .raw_mod3   (raw[0]),
      .raw_mod10  (raw[1]),
      .raw_confirm(raw[2]),
      .raw_enter  (raw[3]),
      .raw_mode   (raw[4]),
      .mod3_btn   (pulse[gi][0]),
      .mod10_btn  (pulse[gi][1]),
      .confirm    (pulse[gi][2]),
      .enter      (pulse[gi][3]),
      .mode       (pulse[gi][4]),
      .busy       (busy[gi])
    );
  end

  int         deb [NI];
  bit         m_s1 [NI][5];
  bit         m_s2 [NI][5];
  bit         m_stable [NI][5];
  int         m_run [NI][5];
  bit         m_pend [NI][5];
  logic [5:0] expv [NI];
  logic [5:0] got [NI];
  int         vectors = 0;
  int         miscompares = 0;
  vec_t       tbl [10];

  // Reference: a level is accepted once it has differed from the stable level
  // for deb consecutive synchronized samples; pending presses drain lowest-first.
  task automatic model_step(input logic [4:0] r, input logic rs);
    for (int n = 0; n < NI; n++) begin
      bit pressed [5];
      int win;
      bit any;
      for (int ch = 0; ch < 5; ch++) begin
        bit seen;
        pressed[ch] = 1'b0;
        seen = m_s2[n][ch];
        if (rs) begin
          m_s1[n][ch] = 0; m_s2[n][ch] = 0; m_stable[n][ch] = 0;
          m_run[n][ch] = 0; m_pend[n][ch] = 0;
        end else begin
          m_s2[n][ch] = m_s1[n][ch];
          m_s1[n][ch] = r[ch];
          if (seen != m_stable[n][ch]) begin
            m_run[n][ch]++;
            if (m_run[n][ch] >= deb[n]) begin
              m_stable[n][ch] = seen;
              m_run[n][ch] = 0;
              pressed[ch] = seen;
            end
          end else begin
            m_run[n][ch] = 0;
          end
        end
      end
      expv[n] = '0;
      if (!rs) begin
        win = -1;
        for (int ch = 4; ch >= 0; ch--) if (m_pend[n][ch]) win = ch;
        if (win >= 0) begin
          expv[n][win] = 1'b1;
          m_pend[n][win] = 1'b0;
        end
        any = 1'b0;
        for (int ch = 0; ch < 5; ch++) begin
          if (pressed[ch]) m_pend[n][ch] = 1'b1;
          any = any | m_pend[n][ch];
        end
        expv[n][5] = any;
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] g, input logic [31:0] e);
    vectors++;
    if (g !== e) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, g, e);
    end
  endtask

  task automatic tick(input logic [4:0] r, input logic rs);
    raw = r;
    rst_btn = rs;
    @(posedge enable);
    model_step(r, rs);
    #1;
    for (int n = 0; n < NI; n++) begin
      got[n] = {busy[n], pulse[n]};
      check($sformatf("model deb=%0d t=%0t", deb[n], $time), 32'(got[n]), 32'(expv[n]));
    end
  endtask

  task automatic idle();
    tick(5'b0, 1'b1);
    for (int i = 0; i < 4; i++) tick(5'b0, 1'b0);
  endtask

  initial begin
    deb[0] = 4; deb[1] = 2; deb[2] = 1;
    // Simultaneous mod3/mod10/mode press, debounce 4: drains at edges 6, 7, 8.
    for (int i = 0; i < 10; i++) begin
      tbl[i].raw = 5'b10011;
      tbl[i].rst = 1'b0;
      tbl[i].exp = 6'b000000;
    end
    tbl[5].exp = 6'b100000;
    tbl[6].exp = 6'b100001;
    tbl[7].exp = 6'b100010;
    tbl[8].exp = 6'b010000;

    raw = 5'b0;
    rst_btn = 1'b1;
    tick(5'b0, 1'b1);
    tick(5'b0, 1'b1);
    for (int n = 0; n < NI; n++) check("reset_state", 32'(got[n]), 32'h0);

    // Single confirm press.
    idle();
    for (int i = 0; i < 12; i++) begin
      logic [5:0] e;
      tick(5'b00100, 1'b0);
      e = (i == 5) ? 6'b100000 : ((i == 6) ? 6'b000100 : 6'b000000);
      check($sformatf("single_press[%0d]", i), 32'(got[0]), 32'(e));
    end
    for (int i = 0; i < 10; i++) tick(5'b0, 1'b0);

    // Glitch reject on enter.
    idle();
    begin
      logic enter_seen, busy_seen;
      enter_seen = 1'b0;
      busy_seen = 1'b0;
      for (int i = 0; i < 18; i++) begin
        tick((i < 3 || (i >= 5 && i < 8)) ? 5'b01000 : 5'b00000, 1'b0);
        enter_seen = enter_seen | got[0][3];
        busy_seen = busy_seen | got[0][5];
      end
      check("glitch_reject", {30'b0, busy_seen, enter_seen}, 32'h0);
    end

    // Simultaneous press table.
    idle();
    for (int i = 0; i < 10; i++) begin
      tick(tbl[i].raw, tbl[i].rst);
      check($sformatf("table[%0d]", i), 32'(got[0]), 32'(tbl[i].exp));
    end
    for (int i = 0; i < 10; i++) tick(5'b0, 1'b0);

    // Held mod10 with a bouncy release.
    idle();
    begin
      int cnt4, cnt2;
      cnt4 = 0;
      cnt2 = 0;
      for (int i = 0; i < 65; i++) begin
        logic b;
        b = (i < 50) ? 1'b1 : ((i == 51 || i == 53) ? 1'b1 : 1'b0);
        tick({3'b0, b, 1'b0}, 1'b0);
        cnt4 += int'(got[0][1]);
        cnt2 += int'(got[1][1]);
      end
      check("held_pulses_deb4", 32'(cnt4), 32'd1);
      check("held_pulses_deb2", 32'(cnt2), 32'd1);
    end

    // Reset in the middle of a five-way queue.
    idle();
    for (int i = 0; i < 21; i++) begin
      logic [5:0] e;
      tick(5'b11111, i == 7);
      e = '0;
      if (i == 6) e = 6'b100001;
      if (i >= 14 && i <= 18) e[i-14] = 1'b1;
      if (i >= 13 && i <= 17) e[5] = 1'b1;
      if (i == 6 || i == 7 || i >= 13)
        check($sformatf("reset_queue[%0d]", i), 32'(got[0]), 32'(e));
    end
    for (int i = 0; i < 15; i++) tick(5'b0, 1'b0);

    // Back-to-back mod3 repress on the debounce-1 instance.
    idle();
    begin
      int cnt, first, second;
      cnt = 0;
      first = -1;
      second = -1;
      for (int i = 0; i < 18; i++) begin
        tick((i < 2 || i == 4 || i == 5) ? 5'b00001 : 5'b00000, 1'b0);
        if (got[2][0]) begin
          if (cnt == 0) first = i;
          else if (cnt == 1) second = i;
          cnt++;
        end
      end
      check("b2b_count", 32'(cnt), 32'd2);
      check("b2b_spacing", 32'(second - first), 32'd4);
    end

    // Randomized bouncing buttons with occasional resets.
    idle();
    begin
      logic [4:0] r;
      r = 5'b0;
      for (int i = 0; i < 600; i++) begin
        for (int b = 0; b < 5; b++) if ($urandom_range(5) == 0) r[b] = ~r[b];
        tick(r, $urandom_range(149) == 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
